ram_sp_arbiter: RTL

RAM_SP_ARBITER -- requirements
Module: ram_sp_arbiter

---
 rtl/ram_sp_arbiter_pkg.sv | 14 +
 rtl/ram_sp_arbiter_tag_pipe.sv | 27 ++
 rtl/ram_sp_arbiter.sv | 105 ++++++++++
 3 files changed

// File: rtl/ram_sp_arbiter_pkg.sv
// Shared types for the two-requester single-port RAM arbiter.
// NUM_REQ is fixed at 2: round-robin reduces to a single last-granted bit.
package ram_sp_arbiter_pkg;

  localparam int NUM_REQ = 2;

  typedef logic req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } rd_tag_t;

endpackage

// File: rtl/ram_sp_arbiter_tag_pipe.sv
// Read-tag delay line matching the RAM read latency; DEPTH cycles push-to-pop.
// No backpressure: one tag enters every cycle, bubbles carry valid = 0.
module ram_sp_arbiter_tag_pipe
  import ram_sp_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    sync_rst,
  input  rd_tag_t push_tag,
  output rd_tag_t pop_tag
);

  rd_tag_t stage [DEPTH];

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= push_tag;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign pop_tag = stage[DEPTH-1];

endmodule

// File: rtl/ram_sp_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between a CSR bridge and an engine.
// Grant is same-cycle; write ack +1 cycle; read data +RAM_RD_LATENCY; losers hold i_req.
module ram_sp_arbiter
  import ram_sp_arbiter_pkg::*;
#(
  parameter int WORD_BIT_WIDTH      = 32,
  parameter int WORD_ADDR_BIT_WIDTH = 3,
  parameter int RAM_RD_LATENCY      = 2
) (
  input  logic                                             i_clk,
  input  logic                                             i_sync_rst,
  input  logic [NUM_REQ-1:0]                               i_req,
  output logic [NUM_REQ-1:0]                               o_gnt,
  input  logic [NUM_REQ-1:0]                               i_we,
  input  logic [NUM_REQ-1:0][WORD_ADDR_BIT_WIDTH-1:0]      i_word_addr,
  input  logic [NUM_REQ-1:0][WORD_BIT_WIDTH-1:0]           i_wr_data,
  input  logic [NUM_REQ-1:0][WORD_BIT_WIDTH/8-1:0]         i_wr_byte_en,
  output logic [NUM_REQ-1:0]                               o_rd_valid,
  output logic [WORD_BIT_WIDTH-1:0]                        o_rd_data,
  output logic [NUM_REQ-1:0]                               o_wr_ack,
  output logic                                             o_ram_we,
  output logic [WORD_ADDR_BIT_WIDTH-1:0]                   o_ram_word_addr,
  output logic [WORD_BIT_WIDTH-1:0]                        o_ram_wr_data,
  output logic [WORD_BIT_WIDTH/8-1:0]                      o_ram_wr_byte_en,
  input  logic [WORD_BIT_WIDTH-1:0]                        i_ram_rd_data
);

  if (!(RAM_RD_LATENCY == 1 || RAM_RD_LATENCY == 2)) begin : g_bad_latency
    $error("ram_sp_arbiter: RAM_RD_LATENCY must be 1 or 2");
  end
  if (WORD_BIT_WIDTH < 8 || (WORD_BIT_WIDTH & (WORD_BIT_WIDTH - 1)) != 0) begin : g_bad_width
    $error("ram_sp_arbiter: WORD_BIT_WIDTH must be a power of 2 and >= 8");
  end

  req_id_t              rr_last;
  req_id_t              sel;
  logic                 acc;
  logic [NUM_REQ-1:0]   wr_ack_q;
  rd_tag_t              push_tag;
  rd_tag_t              pop_tag;

  // On a tie the requester that did not win last time goes next.
  always_comb begin
    o_gnt = '0;
    if (!i_sync_rst) begin
      case (i_req)
        2'b01:   o_gnt = 2'b01;
        2'b10:   o_gnt = 2'b10;
        2'b11:   o_gnt = rr_last ? 2'b01 : 2'b10;
        default: o_gnt = '0;
      endcase
    end
  end

  assign acc = |o_gnt;
  assign sel = o_gnt[1];

  always_comb begin
    o_ram_we         = 1'b0;
    o_ram_word_addr  = '0;
    o_ram_wr_data    = '0;
    o_ram_wr_byte_en = '0;
    if (acc) begin
      o_ram_we         = i_we[sel];
      o_ram_word_addr  = i_word_addr[sel];
      o_ram_wr_data    = i_wr_data[sel];
      o_ram_wr_byte_en = i_wr_byte_en[sel];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_sync_rst) begin
      rr_last  <= 1'b1;
      wr_ack_q <= '0;
    end else begin
      if (acc) rr_last <= sel;
      wr_ack_q <= o_gnt & i_we;
    end
  end

  assign push_tag.valid = acc & ~i_we[sel];
  assign push_tag.id    = sel;

  ram_sp_arbiter_tag_pipe #(
    .DEPTH (RAM_RD_LATENCY)
  ) u_tag_pipe (
    .clk      (i_clk),
    .sync_rst (i_sync_rst),
    .push_tag (push_tag),
    .pop_tag  (pop_tag)
  );

  // Outputs are gated by reset so nothing leaks out during the reset cycle itself.
  always_comb begin
    o_rd_valid = '0;
    o_rd_data  = '0;
    if (!i_sync_rst && pop_tag.valid) begin
      o_rd_valid[pop_tag.id] = 1'b1;
      o_rd_data              = i_ram_rd_data;
    end
  end

  assign o_wr_ack = i_sync_rst ? '0 : wr_ack_q;

endmodule
